// File: rtl/multicycle_control_unit.sv
// Main control FSM for the multicycle RV64I-subset CPU.
// Sequences fetch/decode/execute/memory/writeback one state per clock and
// drives every datapath write enable and mux select.
// Optional feature: define OVERFLOW_TRAP_EN to trap signed ADD/SUB overflow
// (cause=2) instead of writing back the wrapped result.
module multicycle_control_unit #(
    parameter int          MEM_LAT    = 2,
    parameter logic [63:0] EXC_VECTOR = 64'd255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7_5,
    input  logic        alu_igual,
    input  logic        alu_menor,
    input  logic        alu_maior,
    input  logic        alu_overflow,
    output logic [4:0]  estado,
    output logic        pc_wr,
    output logic        ir_wr,
    output logic        reg_wr,
    output logic        mem_wr,
    output logic        mdr_wr,
    output logic        a_b_wr,
    output logic        aluout_wr,
    output logic        epc_wr,
    output logic        cause_wr,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_op,
    output logic [1:0]  wb_sel,
    output logic [1:0]  pc_src,
    output logic [2:0]  cause,
    output logic [63:0] exc_vector,
    output logic        halted
);

    typedef enum logic [4:0] {
        S_RST        = 5'd0,
        S_FETCH      = 5'd1,
        S_FETCH_WAIT = 5'd2,
        S_DECODE     = 5'd3,
        S_EXEC_R     = 5'd4,
        S_EXEC_I     = 5'd5,
        S_ADDR       = 5'd6,
        S_LD_REQ     = 5'd7,
        S_LD_WAIT    = 5'd8,
        S_LD_WB      = 5'd9,
        S_ST         = 5'd10,
        S_ALU_WB     = 5'd11,
        S_BRANCH     = 5'd12,
        S_JAL        = 5'd13,
        S_LUI        = 5'd14,
        S_EXC        = 5'd15,
        S_EXC_VEC    = 5'd16,
        S_HALT       = 5'd17
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] ALU_ADD    = 3'd0;
    localparam logic [2:0] ALU_SUB    = 3'd1;
    localparam logic [2:0] ALU_AND    = 3'd2;
    localparam logic [2:0] ALU_OR     = 3'd3;
    localparam logic [2:0] ALU_XOR    = 3'd4;
    localparam logic [2:0] ALU_PASS_B = 3'd5;

    localparam logic [2:0] CAUSE_INVALID  = 3'd1;
    localparam logic [2:0] CAUSE_OVERFLOW = 3'd2;

    // Last cycle of a memory wait: MEM_LAT-1 extra cycles after the request.
    localparam logic [2:0] LAST_WAIT = 3'(MEM_LAT - 1);

    state_t     state_q, state_d;
    logic [2:0] wait_cnt_q, wait_cnt_d;
    logic [2:0] cause_q, cause_d;

    logic [2:0] exec_op;
    logic       exec_valid;
    logic       exec_arith;
    logic       ovf_trap;
    logic       branch_taken;
    logic       wait_last;

    assign wait_last  = (wait_cnt_q == LAST_WAIT);
    assign exc_vector = EXC_VECTOR;
    assign estado     = state_q;

    // ALU function for EXEC_R/EXEC_I; funct7_5 selects SUB only for R-type.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        exec_op    = ALU_ADD;
        exec_valid = 1'b1;
        exec_arith = 1'b0;
        case (funct3)
            3'b000: begin
                exec_arith = 1'b1;
                exec_op    = (state_q == S_EXEC_R && funct7_5) ? ALU_SUB : ALU_ADD;
            end
            3'b111:  exec_op = ALU_AND;
            3'b110:  exec_op = ALU_OR;
            3'b100:  exec_op = ALU_XOR;
            default: exec_valid = 1'b0;
        endcase
    end

`ifdef OVERFLOW_TRAP_EN
    assign ovf_trap = exec_arith & alu_overflow;
`else
    // Overflow wraps around; the flag is intentionally not consumed.
    logic unused_overflow;
    assign unused_overflow = alu_overflow;
    assign ovf_trap        = 1'b0;
`endif

    // The greater-than flag is not needed by the supported branch set.
    logic unused_maior;
    assign unused_maior = alu_maior;

    // Branch condition from funct3 and the signed compare flags.
    always_comb begin
        case (funct3)
            3'b000:  branch_taken = alu_igual;
            3'b001:  branch_taken = !alu_igual;
            3'b100:  branch_taken = alu_menor;
            3'b101:  branch_taken = !alu_menor;
            default: branch_taken = 1'b0;
        endcase
    end

    // State, wait counter and pending cause registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q    <= S_RST;
            wait_cnt_q <= 3'd0;
            cause_q    <= 3'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            cause_q    <= cause_d;
        end
    end

    // Next-state logic; exception entry wins over every other transition.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        cause_d    = cause_q;
        case (state_q)
            S_RST:   state_d = S_FETCH;
            S_FETCH: state_d = S_FETCH_WAIT;
            S_FETCH_WAIT, S_LD_WAIT: begin
                if (wait_last) begin
                    wait_cnt_d = 3'd0;
                    state_d    = (state_q == S_FETCH_WAIT) ? S_DECODE : S_LD_WB;
                end else begin
                    wait_cnt_d = wait_cnt_q + 3'd1;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_R:               state_d = S_EXEC_R;
                    OP_I:               state_d = S_EXEC_I;
                    OP_LOAD, OP_STORE:  state_d = S_ADDR;
                    OP_BRANCH:          state_d = S_BRANCH;
                    OP_JAL:             state_d = S_JAL;
                    OP_LUI:             state_d = S_LUI;
                    OP_SYSTEM:          state_d = S_HALT;
                    default: begin
                        state_d = S_EXC;
                        cause_d = CAUSE_INVALID;
                    end
                endcase
            end
            S_EXEC_R, S_EXEC_I: begin
                if (!exec_valid) begin
                    state_d = S_EXC;
                    cause_d = CAUSE_INVALID;
                end else if (ovf_trap) begin
                    state_d = S_EXC;
                    cause_d = CAUSE_OVERFLOW;
                end else begin
                    state_d = S_ALU_WB;
                end
            end
            S_ADDR:    state_d = (opcode == OP_LOAD) ? S_LD_REQ : S_ST;
            S_LD_REQ:  state_d = S_LD_WAIT;
            S_LUI:     state_d = S_ALU_WB;
            S_EXC:     state_d = S_EXC_VEC;
            S_HALT:    state_d = S_HALT;
            S_LD_WB, S_ST, S_ALU_WB, S_BRANCH, S_JAL, S_EXC_VEC:
                       state_d = S_FETCH;
            default:   state_d = S_RST;
        endcase
    end

    // Moore outputs per state; only the BRANCH pc_wr looks at the flags.
    always_comb begin
        pc_wr     = 1'b0;
        ir_wr     = 1'b0;
        reg_wr    = 1'b0;
        mem_wr    = 1'b0;
        mdr_wr    = 1'b0;
        a_b_wr    = 1'b0;
        aluout_wr = 1'b0;
        epc_wr    = 1'b0;
        cause_wr  = 1'b0;
        alu_src_a = 1'b0;
        alu_src_b = 2'd0;
        alu_op    = ALU_ADD;
        wb_sel    = 2'd0;
        pc_src    = 2'd0;
        cause     = 3'd0;
        halted    = 1'b0;
        case (state_q)
            S_FETCH: begin
                alu_src_b = 2'd1;
                pc_wr     = 1'b1;
            end
            S_FETCH_WAIT: ir_wr = wait_last;
            S_DECODE: begin
                a_b_wr    = 1'b1;
                alu_src_b = 2'd2;
                aluout_wr = 1'b1;
            end
            S_EXEC_R, S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = (state_q == S_EXEC_I) ? 2'd2 : 2'd0;
                alu_op    = exec_op;
                aluout_wr = 1'b1;
            end
            S_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                aluout_wr = 1'b1;
            end
            S_LD_WAIT: mdr_wr = wait_last;
            S_LD_WB: begin
                reg_wr = 1'b1;
                wb_sel = 2'd1;
            end
            S_ST:     mem_wr = 1'b1;
            S_ALU_WB: reg_wr = 1'b1;
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = 2'd1;
                pc_wr     = branch_taken;
            end
            S_JAL: begin
                reg_wr = 1'b1;
                wb_sel = 2'd2;
                pc_wr  = 1'b1;
                pc_src = 2'd1;
            end
            S_LUI: begin
                alu_src_b = 2'd2;
                alu_op    = ALU_PASS_B;
                aluout_wr = 1'b1;
            end
            S_EXC: begin
                alu_src_b = 2'd1;
                alu_op    = ALU_SUB;
                epc_wr    = 1'b1;
                cause_wr  = 1'b1;
                cause     = cause_q;
            end
            S_EXC_VEC: begin
                pc_wr  = 1'b1;
                pc_src = 2'd2;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit (MEM_LAT=2).
// Cycle-by-cycle vectors of {IR fields, flags, expected state, expected
// control word} are queued per instruction, then applied and compared.
module tb_multicycle_control_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic [2:0]  funct3 = 3'd0;
    logic        funct7_5 = 1'b0;
    logic        alu_igual = 1'b0, alu_menor = 1'b0, alu_maior = 1'b0, alu_overflow = 1'b0;
    logic [4:0]  estado;
    logic        pc_wr, ir_wr, reg_wr, mem_wr, mdr_wr, a_b_wr, aluout_wr, epc_wr, cause_wr;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_op;
    logic [1:0]  wb_sel;
    logic [1:0]  pc_src;
    logic [2:0]  cause;
    logic [63:0] exc_vector;
    logic        halted;

    multicycle_control_unit #(.MEM_LAT(2), .EXC_VECTOR(64'd255)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .funct3(funct3),
        .funct7_5(funct7_5), .alu_igual(alu_igual), .alu_menor(alu_menor),
        .alu_maior(alu_maior), .alu_overflow(alu_overflow), .estado(estado),
        .pc_wr(pc_wr), .ir_wr(ir_wr), .reg_wr(reg_wr), .mem_wr(mem_wr),
        .mdr_wr(mdr_wr), .a_b_wr(a_b_wr), .aluout_wr(aluout_wr), .epc_wr(epc_wr),
        .cause_wr(cause_wr), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .wb_sel(wb_sel), .pc_src(pc_src), .cause(cause),
        .exc_vector(exc_vector), .halted(halted)
    );

    always #5 clock = ~clock;

    // Observed control word: enables{pc,ir,reg,mem,mdr,ab,aluout,epc,cause},
    // src_a, src_b, alu_op, wb_sel, pc_src, cause, halted.
    logic [22:0] obs;
    assign obs = {pc_wr, ir_wr, reg_wr, mem_wr, mdr_wr, a_b_wr, aluout_wr, epc_wr,
                  cause_wr, alu_src_a, alu_src_b, alu_op, wb_sel, pc_src, cause, halted};

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7;
        logic [3:0]  flg;   // {igual, menor, maior, overflow}
        logic [4:0]  st;
        logic [22:0] ctl;
    } vec_t;

    vec_t vq[$];
    int   total = 0;
    int   bad   = 0;

    logic [6:0] cur_opc;
    logic [2:0] cur_f3;
    logic       cur_f7;
    logic [3:0] cur_flg;

    localparam logic [4:0] S_RST = 5'd0, S_FETCH = 5'd1, S_FW = 5'd2, S_DEC = 5'd3,
        S_EXR = 5'd4, S_EXI = 5'd5, S_ADDR = 5'd6, S_LDREQ = 5'd7, S_LDW = 5'd8,
        S_LDWB = 5'd9, S_ST = 5'd10, S_AWB = 5'd11, S_BR = 5'd12, S_JAL = 5'd13,
        S_LUI = 5'd14, S_EXC = 5'd15, S_EXCV = 5'd16, S_HALT = 5'd17;

    function automatic logic [22:0] cw(input logic [8:0] en, input logic sa,
                                       input logic [1:0] sb, input logic [2:0] op,
                                       input logic [1:0] wb, input logic [1:0] ps,
                                       input logic [2:0] ca, input logic h);
        return {en, sa, sb, op, wb, ps, ca, h};
    endfunction

    logic [22:0] C_ZERO, C_FETCH, C_FW1, C_DEC, C_AWB, C_ADDR, C_LDW1, C_LDWB, C_ST,
                 C_BR_T, C_BR_N, C_JAL, C_LUI, C_EXCV, C_HALT;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [4:0] st, input logic [22:0] ctl);
        vec_t v;
        v.opc = cur_opc; v.f3 = cur_f3; v.f7 = cur_f7; v.flg = cur_flg;
        v.st = st; v.ctl = ctl;
        vq.push_back(v);
    endtask

    // Start an instruction: FETCH, two FETCH_WAIT cycles, DECODE.
    task automatic instr(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                         input logic [3:0] flg);
        cur_opc = opc; cur_f3 = f3; cur_f7 = f7; cur_flg = flg;
        add(S_FETCH, C_FETCH);
        add(S_FW, C_ZERO);
        add(S_FW, C_FW1);
        add(S_DEC, C_DEC);
    endtask

    // Apply queued vectors: inputs just after the rising edge, check at falling edge.
    task automatic run_vectors(input string tag);
        for (int i = 0; i < vq.size(); i++) begin
            @(posedge clock);
            #1;
            opcode = vq[i].opc; funct3 = vq[i].f3; funct7_5 = vq[i].f7;
            {alu_igual, alu_menor, alu_maior, alu_overflow} = vq[i].flg;
            @(negedge clock);
            check($sformatf("%s[%0d] estado", tag, i), 64'(estado), 64'(vq[i].st));
            check($sformatf("%s[%0d] ctl", tag, i), 64'(obs), 64'(vq[i].ctl));
        end
        vq.delete();
    endtask

    initial begin
        C_ZERO  = 23'd0;
        C_FETCH = cw(9'b100000000, 1'b0, 2'd1, 3'd0, 2'd0, 2'd0, 3'd0, 1'b0);
        C_FW1   = cw(9'b010000000, 1'b0, 2'd0, 3'd0, 2'd0, 2'd0, 3'd0, 1'b0);
        C_DEC   = cw(9'b000001100, 1'b0, 2'd2, 3'd0, 2'd0, 2'd0, 3'd0, 1'b0);
        C_AWB   = cw(9'b001000000, 1'b0, 2'd0, 3'd0, 2'd0, 2'd0, 3'd0, 1'b0);
        C_ADDR  = cw(9'b000000100, 1'b1, 2'd2, 3'd0, 2'd0, 2'd0, 3'd0, 1'b0);
        C_LDW1  = cw(9'b000010000, 1'b0, 2'd0, 3'd0, 2'd0, 2'd0, 3'd0, 1'b0);
        C_LDWB  = cw(9'b001000000, 1'b0, 2'd0, 3'd0, 2'd1, 2'd0, 3'd0, 1'b0);
        C_ST    = cw(9'b000100000, 1'b0, 2'd0, 3'd0, 2'd0, 2'd0, 3'd0, 1'b0);
        C_BR_T  = cw(9'b100000000, 1'b1, 2'd0, 3'd1, 2'd0, 2'd1, 3'd0, 1'b0);
        C_BR_N  = cw(9'b000000000, 1'b1, 2'd0, 3'd1, 2'd0, 2'd1, 3'd0, 1'b0);
        C_JAL   = cw(9'b101000000, 1'b0, 2'd0, 3'd0, 2'd2, 2'd1, 3'd0, 1'b0);
        C_LUI   = cw(9'b000000100, 1'b0, 2'd2, 3'd5, 2'd0, 2'd0, 3'd0, 1'b0);
        C_EXCV  = cw(9'b100000000, 1'b0, 2'd0, 3'd0, 2'd0, 2'd2, 3'd0, 1'b0);
        C_HALT  = cw(9'b000000000, 1'b0, 2'd0, 3'd0, 2'd0, 2'd0, 3'd0, 1'b1);

        // Reset held for three cycles: state RST, everything quiet.
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check($sformatf("reset%0d estado", i), 64'(estado), 64'(S_RST));
            check($sformatf("reset%0d ctl", i), 64'(obs), 64'(C_ZERO));
        end
        check("exc_vector", exc_vector, 64'd255);
        reset = 1'b1;

        // add x3,x1,x2
        instr(7'b0110011, 3'b000, 1'b0, 4'b0000);
        add(S_EXR, cw(9'b000000100, 1'b1, 2'd0, 3'd0, 2'd0, 2'd0, 3'd0, 1'b0));
        add(S_AWB, C_AWB);
        // sub
        instr(7'b0110011, 3'b000, 1'b1, 4'b0000);
        add(S_EXR, cw(9'b000000100, 1'b1, 2'd0, 3'd1, 2'd0, 2'd0, 3'd0, 1'b0));
        add(S_AWB, C_AWB);
        // and with overflow flag set: never trapped (not ADD/SUB)
        instr(7'b0110011, 3'b111, 1'b0, 4'b0001);
        add(S_EXR, cw(9'b000000100, 1'b1, 2'd0, 3'd2, 2'd0, 2'd0, 3'd0, 1'b0));
        add(S_AWB, C_AWB);
        // ori, xori (funct7_5 ignored), addi (funct7_5 ignored)
        instr(7'b0010011, 3'b110, 1'b0, 4'b0000);
        add(S_EXI, cw(9'b000000100, 1'b1, 2'd2, 3'd3, 2'd0, 2'd0, 3'd0, 1'b0));
        add(S_AWB, C_AWB);
        instr(7'b0010011, 3'b100, 1'b1, 4'b0000);
        add(S_EXI, cw(9'b000000100, 1'b1, 2'd2, 3'd4, 2'd0, 2'd0, 3'd0, 1'b0));
        add(S_AWB, C_AWB);
        instr(7'b0010011, 3'b000, 1'b1, 4'b0000);
        add(S_EXI, cw(9'b000000100, 1'b1, 2'd2, 3'd0, 2'd0, 2'd0, 3'd0, 1'b0));
        add(S_AWB, C_AWB);
        // ld
        instr(7'b0000011, 3'b011, 1'b0, 4'b0000);
        add(S_ADDR, C_ADDR);
        add(S_LDREQ, C_ZERO);
        add(S_LDW, C_ZERO);
        add(S_LDW, C_LDW1);
        add(S_LDWB, C_LDWB);
        // sd
        instr(7'b0100011, 3'b011, 1'b0, 4'b0000);
        add(S_ADDR, C_ADDR);
        add(S_ST, C_ST);
        // beq taken, bne not taken, blt taken, bge (not less) taken, bge not taken, funct3=010 never
        instr(7'b1100011, 3'b000, 1'b0, 4'b1000);
        add(S_BR, C_BR_T);
        instr(7'b1100011, 3'b001, 1'b0, 4'b1000);
        add(S_BR, C_BR_N);
        instr(7'b1100011, 3'b100, 1'b0, 4'b0100);
        add(S_BR, C_BR_T);
        instr(7'b1100011, 3'b101, 1'b0, 4'b0010);
        add(S_BR, C_BR_T);
        instr(7'b1100011, 3'b101, 1'b0, 4'b0100);
        add(S_BR, C_BR_N);
        instr(7'b1100011, 3'b010, 1'b0, 4'b1000);
        add(S_BR, C_BR_N);
        // jal, lui
        instr(7'b1101111, 3'b000, 1'b0, 4'b0000);
        add(S_JAL, C_JAL);
        instr(7'b0110111, 3'b000, 1'b0, 4'b0000);
        add(S_LUI, C_LUI);
        add(S_AWB, C_AWB);
        // invalid opcode -> EXC cause 1
        instr(7'b1111111, 3'b000, 1'b0, 4'b0000);
        add(S_EXC, cw(9'b000000011, 1'b0, 2'd1, 3'd1, 2'd0, 2'd0, 3'd1, 1'b0));
        add(S_EXCV, C_EXCV);
        // R-type with unsupported funct3 -> EXC cause 1
        instr(7'b0110011, 3'b001, 1'b0, 4'b0000);
        add(S_EXR, cw(9'b000000100, 1'b1, 2'd0, 3'd0, 2'd0, 2'd0, 3'd0, 1'b0));
        add(S_EXC, cw(9'b000000011, 1'b0, 2'd1, 3'd1, 2'd0, 2'd0, 3'd1, 1'b0));
        add(S_EXCV, C_EXCV);
        // add with signed overflow
        instr(7'b0110011, 3'b000, 1'b0, 4'b0001);
        add(S_EXR, cw(9'b000000100, 1'b1, 2'd0, 3'd0, 2'd0, 2'd0, 3'd0, 1'b0));
`ifdef OVERFLOW_TRAP_EN
        add(S_EXC, cw(9'b000000011, 1'b0, 2'd1, 3'd1, 2'd0, 2'd0, 3'd2, 1'b0));
        add(S_EXCV, C_EXCV);
`else
        add(S_AWB, C_AWB);
`endif
        run_vectors("prog");

        // Load interrupted by reset in its last wait cycle.
        instr(7'b0000011, 3'b011, 1'b0, 4'b0000);
        add(S_ADDR, C_ADDR);
        add(S_LDREQ, C_ZERO);
        add(S_LDW, C_ZERO);
        add(S_LDW, C_LDW1);
        run_vectors("ld_pre");
        #1 reset = 1'b0;
        #1;
        check("async reset estado", 64'(estado), 64'(S_RST));
        check("async reset ctl", 64'(obs), 64'(C_ZERO));
        @(negedge clock);
        check("reset hold estado", 64'(estado), 64'(S_RST));
        reset = 1'b1;

        // Restart: the wait counter must be back at 0 (ir_wr only on the 2nd wait cycle),
        // then halt and stay halted.
        instr(7'b1110011, 3'b000, 1'b0, 4'b0000);
        add(S_HALT, C_HALT);
        add(S_HALT, C_HALT);
        add(S_HALT, C_HALT);
        run_vectors("halt");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Main control FSM for the multicycle RV64I-subset CPU datapath (PC, IR, register bank, A/B, ALU, ALUOut, MDR, EPC, cause register, unified 64-bit memory).
- Decodes the IR fields and sequences fetch, decode, execute, memory and writeback one state per clock.
- Drives every datapath write-enable and mux select.
- Handles invalid-opcode and overflow exceptions through EPC and the cause register.
- Exports the current state on `estado` for the CPU debug/monitor outputs.

Parameters:
- MEM_LAT, 2, memory read latency in cycles (1..7). The FSM waits MEM_LAT-1 extra cycles after each read request.
- EXC_VECTOR, 64'd255, PC value loaded on any exception.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7_5  in  1  IR[30]
- alu_igual / alu_menor / alu_maior  in  1 each  ALU compare flags (A vs B, signed)
- alu_overflow  in  1  ALU signed overflow
- estado  out  5  current state code
- pc_wr, ir_wr, reg_wr, mem_wr, mdr_wr, a_b_wr, aluout_wr, epc_wr, cause_wr  out  1 each  register/memory write enables
- alu_src_a  out  1  0=PC, 1=A
- alu_src_b  out  2  0=B, 1=const 4, 2=immediate
- alu_op  out  3  0=ADD, 1=SUB, 2=AND, 3=OR, 4=XOR, 5=PASS_B
- wb_sel  out  2  0=ALUOut, 1=MDR, 2=PC (link)
- pc_src  out  2  0=ALU, 1=ALUOut, 2=EXC_VECTOR
- cause  out  3  cause code to latch: 1=invalid opcode, 2=overflow
- exc_vector  out  64  constant EXC_VECTOR
- halted  out  1  high while in HALT

Behaviour:
- Reset (reset=0): state=RST(0). All enables 0, selects 0, cause=0, halted=0, wait counter=0. Takes effect immediately, including mid-instruction.
- Outputs are Moore (decoded from state only), except the BRANCH pc_wr, which uses the flags. Every unlisted signal is 0 in every state.
- RST(0): after reset deasserts, go to FETCH on the next edge.
- FETCH(1): memory read at PC; ALU computes PC+4 (src_a=0, src_b=1, ADD); pc_wr=1, pc_src=0. Go to FETCH_WAIT.
- FETCH_WAIT(2): ir_wr=1 on the last wait cycle. Counter runs 0..MEM_LAT-1; leave when counter==MEM_LAT-1 and reset it to 0.
- DECODE(3): a_b_wr=1; ALU computes PC+imm (src_a=0, src_b=2, ADD); aluout_wr=1 (branch target). Next state by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> ADDR
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 0110111 -> LUI
  - 1110011 -> HALT
  - anything else -> EXC with cause=1
- EXEC_R(4): src_a=1, src_b=0; aluout_wr=1. alu_op from funct3/funct7_5: 000/0=ADD, 000/1=SUB, 111=AND, 110=OR, 100=XOR; other codes go to EXC with cause=1. Next ALU_WB.
- EXEC_I(5): same as EXEC_R with src_b=2, and funct7_5 is ignored (always ADD for funct3=000).
- ADDR(6): ADD of A+imm; aluout_wr=1. Go to LD_REQ if opcode is load, else ST.
- LD_REQ(7) and LD_WAIT(8):
  - LD_REQ: memory read at ALUOut.
  - LD_WAIT: counts like FETCH_WAIT, mdr_wr=1 on its last cycle, then go to LD_WB.
- LD_WB(9): reg_wr=1, wb_sel=1. Go to FETCH.
- ST(10): mem_wr=1 for exactly one cycle. Go to FETCH.
- ALU_WB(11): reg_wr=1, wb_sel=0. Go to FETCH.
- BRANCH(12): SUB of A-B; pc_src=1. Go to FETCH. pc_wr=1 when:
  - funct3=000 and alu_igual
  - funct3=001 and !alu_igual
  - funct3=100 and alu_menor
  - funct3=101 and !alu_menor
  - Other funct3 values: no write.
- JAL(13): reg_wr=1 with wb_sel=2 (rd<=PC, already PC+4); pc_wr=1 with pc_src=1. Go to FETCH.
- LUI(14): src_b=2, alu_op=PASS_B; aluout_wr=1. Go to ALU_WB.
- EXC(15): SUB of PC-4 (src_a=0, src_b=1); epc_wr=1, cause_wr=1, cause held from the entry decision. Go to EXC_VEC.
- EXC_VEC(16): pc_wr=1, pc_src=2. Go to FETCH.
- HALT(17): halted=1, no enables. Stays in HALT until reset.
- reg_wr to x0 is allowed; the register bank ignores it.
- If two events coincide, exception entry takes priority over every other transition.

Optional Feature:
- Macro: OVERFLOW_TRAP_EN.
- Defined: in EXEC_R/EXEC_I, an ADD or SUB with alu_overflow=1 goes to EXC with cause=2 instead of ALU_WB. aluout_wr still pulses, but reg_wr never asserts for that instruction.
- Undefined: alu_overflow is ignored and the result is written back (wrap-around).

Test Plan:
- Reset held 3 cycles, then released -> estado=0 during reset; sequence 0→1→2→3 with MEM_LAT=2; ir_wr high only in the 2nd FETCH_WAIT cycle; pc_wr exactly once in FETCH.
- add x3,x1,x2 (x1=5, x2=7) -> states 1,2,2,3,4,11,1; reg_wr for one cycle; x3=12.
- ld then sd at address 64 -> LD path 6,7,8,8,9 with mdr_wr once; ST path 6,10 with mem_wr high exactly one cycle.
- beq with A=B=9 -> pc_wr in BRANCH with pc_src=1. Then bne with A=B -> no pc_wr, PC advances by only 4.
- Opcode 7'b1111111 at PC=16 -> states 3,15,16,1; EPC=16; cause=1; PC=255.
- With OVERFLOW_TRAP_EN: add of 0x7FFF_FFFF_FFFF_FFFF+1 -> EXC with cause=2, no reg_wr. Without the macro: rd=0x8000_0000_0000_0000. Also assert reset mid-LD_WAIT -> estado=0 immediately.
